can_mc_bus_ctrl: RTL and testbench

CAN_MC_BUS_CTRL -- requirements
Module: can_mc_bus_ctrl

---
 rtl/can_mc_pkg.sv | 26 ++
 rtl/can_mc_addr_chk.sv | 22 ++
 rtl/can_mc_bus_ctrl.sv | 122 ++++++++++++
 tb/tb_can_mc_bus_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_mc_pkg.sv
// can_mc_pkg: shared types and constants for the CAN controller CPU bus
// interface. Holds the transaction FSM state encoding, the readable and
// writable address window limits, and the bus widths.
package can_mc_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    // Readable windows: [0x00, RD_LO_END] and [RD_HI_START, RD_HI_END].
    // Writable window: [0x00, WR_END].
    localparam logic [ADDR_W-1:0] RD_LO_END   = 6'h08;
    localparam logic [ADDR_W-1:0] RD_HI_START = 6'h14;
    localparam logic [ADDR_W-1:0] RD_HI_END   = 6'h20;
    localparam logic [ADDR_W-1:0] WR_END      = 6'h13;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_ACK  = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4,
        ST_HOLD    = 3'd5
    } state_e;

endpackage

// File: rtl/can_mc_addr_chk.sv
// can_mc_addr_chk: combinational address validity check for one access
// direction.
//   i_addr     - register address under test
//   i_is_write - 1: check against the writable window, 0: readable windows
//   o_valid    - 1 when the address is legal for that direction
module can_mc_addr_chk
    import can_mc_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_is_write,
    output logic              o_valid
);

    logic w_rd_ok;
    logic w_wr_ok;

    assign w_rd_ok = (i_addr <= RD_LO_END) ||
                     ((i_addr >= RD_HI_START) && (i_addr <= RD_HI_END));
    assign w_wr_ok = (i_addr <= WR_END);
    assign o_valid = i_is_write ? w_wr_ok : w_rd_ok;

endmodule

// File: rtl/can_mc_bus_ctrl.sv
// can_mc_bus_ctrl: bridges a simple CPU chip-select bus onto separate read
// and write register channels of the CAN core.
//   CPU side : i_cs, i_rd, i_wr, i_addr, i_wdata in; o_rdata, o_ready, o_err out
//   Read ch. : o_rd_en, o_rd_addr, o_ack out; i_rd_data in
//   Write ch.: o_wr_en, o_wr_addr, o_wr_data out
//
// Handshake: the CPU raises i_cs with exactly one of i_rd/i_wr and keeps
// i_cs high until it sees o_ready. A request is taken on the first IDLE edge
// where that holds; o_ready is a single-cycle pulse with o_rdata/o_err valid
// alongside it. The controller then parks in HOLD until i_cs drops, so one
// long chip-select yields exactly one transaction.
module can_mc_bus_ctrl
    import can_mc_pkg::*;
#(
    parameter int RD_WAIT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cs,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_err,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_ack,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data
);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic w_rd_req;
    logic w_wr_req;
    logic w_both_req;
    logic w_addr_ok;
    logic w_wait_done;

    assign w_rd_req   = i_cs & i_rd & ~i_wr;
    assign w_wr_req   = i_cs & i_wr & ~i_rd;
    assign w_both_req = i_cs & i_rd & i_wr;

    // Counter runs 0..RD_WAIT-1, giving exactly RD_WAIT cycles in RD_WAIT.
    assign w_wait_done = (r_cnt == CNT_W'(RD_WAIT - 1));

    can_mc_addr_chk u_addr_chk (
        .i_addr     (i_addr),
        .i_is_write (w_wr_req),
        .o_valid    (w_addr_ok)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_req || w_wr_req || w_both_req) begin
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_cnt   <= '0;
                        if (!w_both_req && w_addr_ok) begin
                            r_err   <= 1'b0;
                            r_state <= w_rd_req ? ST_RD_WAIT : ST_WR;
                        end else begin
                            // Error responses carry no data.
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (w_wait_done) begin
                        r_state <= ST_RD_ACK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RD_ACK: begin
                    r_rdata <= i_rd_data;
                    r_state <= ST_RESP;
                end
                ST_WR:   r_state <= ST_RESP;
                ST_RESP: r_state <= ST_HOLD;
                ST_HOLD: begin
                    if (!i_cs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode the state register only; CPU inputs never reach them.
    assign o_rd_en   = (r_state == ST_RD_WAIT) || (r_state == ST_RD_ACK);
    assign o_ack     = (r_state == ST_RD_ACK);
    assign o_wr_en   = (r_state == ST_WR);
    assign o_ready   = (r_state == ST_RESP);
    assign o_rd_addr = r_addr;
    assign o_wr_addr = r_addr;
    assign o_wr_data = r_wdata;
    assign o_rdata   = r_rdata;
    assign o_err     = r_err;

endmodule

// File: tb/tb_can_mc_bus_ctrl.sv
// tb_can_mc_bus_ctrl: directed self-checking bench for can_mc_bus_ctrl with
// RD_WAIT=2. Latencies are reported in edges from the accepting edge to the
// edge at which o_ready is sampled high.
module tb_can_mc_bus_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_cs = 1'b0;
    logic        i_rd = 1'b0;
    logic        i_wr = 1'b0;
    logic [5:0]  i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] i_rd_data = '0;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_err;
    logic        o_rd_en;
    logic [5:0]  o_rd_addr;
    logic        o_ack;
    logic        o_wr_en;
    logic [5:0]  o_wr_addr;
    logic [31:0] o_wr_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Results of the most recent run_txn call.
    int          t_lat, t_nrd, t_nwr, t_nack, t_ackpos, t_badaddr;
    logic [31:0] t_rdata, t_wd;
    logic        t_err;
    logic [5:0]  t_wa;

    can_mc_bus_ctrl #(.RD_WAIT(2)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_cs      (i_cs),
        .i_rd      (i_rd),
        .i_wr      (i_wr),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .o_rdata   (o_rdata),
        .o_ready   (o_ready),
        .o_err     (o_err),
        .o_rd_en   (o_rd_en),
        .o_rd_addr (o_rd_addr),
        .o_ack     (o_ack),
        .i_rd_data (i_rd_data),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data)
    );

    // ---- clock / reset ----
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // ---- driver tasks ----
    // Issue one request, scramble the CPU inputs after acceptance, and
    // observe the channels until o_ready (bounded).
    task automatic run_txn(input logic rd, input logic wr, input logic [5:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdin,
                           input bit drop_cs);
        t_lat = -1; t_nrd = 0; t_nwr = 0; t_nack = 0; t_ackpos = 0; t_badaddr = 0;
        t_rdata = 32'hxxxxxxxx; t_err = 1'bx; t_wa = 6'h00; t_wd = 32'h0;
        i_cs = 1'b1; i_rd = rd; i_wr = wr; i_addr = addr; i_wdata = wdata; i_rd_data = rdin;
        tick();
        i_cs = !drop_cs; i_rd = 1'b0; i_wr = 1'b0; i_addr = 6'h3F; i_wdata = 32'h0;
        for (int n = 0; n < 40; n++) begin
            if (o_rd_en) begin
                t_nrd++;
                if (o_rd_addr !== addr) t_badaddr++;
            end
            if (o_ack) begin
                t_nack++;
                t_ackpos = t_nrd;
            end
            if (o_wr_en) begin
                t_nwr++;
                t_wa = o_wr_addr;
                t_wd = o_wr_data;
            end
            if (o_ready) begin
                t_lat = n + 1;
                t_rdata = o_rdata;
                t_err = o_err;
                break;
            end
            tick();
        end
    endtask

    // Drop chip select and let the controller return to IDLE.
    task automatic end_txn();
        i_cs = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // ---- tests ----
    task automatic test_reset();
        i_reset_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({o_rd_en, o_ack, o_wr_en, o_ready, o_err} !== 5'b0)
            $display("FAIL reset_strobes: got %b expected 00000", {o_rd_en, o_ack, o_wr_en, o_ready, o_err});
        else pass_cnt++;
        total_cnt++;
        if ({o_rdata, o_wr_data} !== 64'h0)
            $display("FAIL reset_data: got %h expected 0", {o_rdata, o_wr_data});
        else pass_cnt++;
        total_cnt++;
        if ({o_rd_addr, o_wr_addr} !== 12'h0)
            $display("FAIL reset_addr: got %h expected 000", {o_rd_addr, o_wr_addr});
        else pass_cnt++;
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
    endtask

    task automatic test_read();
        // Accepted on the first edge after reset release.
        run_txn(1'b1, 1'b0, 6'h03, 32'h0, 32'hDEADBEEF, 1'b0);
        total_cnt++;
        if (t_lat !== 4) $display("FAIL read_latency: got %0d expected 4", t_lat);
        else pass_cnt++;
        total_cnt++;
        if (t_nrd !== 3) $display("FAIL read_rd_en_cycles: got %0d expected 3", t_nrd);
        else pass_cnt++;
        total_cnt++;
        if (t_nack !== 1 || t_ackpos !== 3)
            $display("FAIL read_ack: got count %0d pos %0d expected count 1 pos 3", t_nack, t_ackpos);
        else pass_cnt++;
        total_cnt++;
        if (t_badaddr !== 0) $display("FAIL read_rd_addr: got %0d bad cycles expected 0", t_badaddr);
        else pass_cnt++;
        total_cnt++;
        if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0)
            $display("FAIL read_data: got %h err %b expected deadbeef err 0", t_rdata, t_err);
        else pass_cnt++;
        end_txn();
    endtask

    task automatic test_write();
        run_txn(1'b0, 1'b1, 6'h10, 32'h12345678, 32'h0, 1'b0);
        total_cnt++;
        if (t_lat !== 2) $display("FAIL write_latency: got %0d expected 2", t_lat);
        else pass_cnt++;
        total_cnt++;
        if (t_nwr !== 1 || t_nrd !== 0)
            $display("FAIL write_strobe: got wr %0d rd %0d expected wr 1 rd 0", t_nwr, t_nrd);
        else pass_cnt++;
        total_cnt++;
        if (t_wa !== 6'h10 || t_wd !== 32'h12345678)
            $display("FAIL write_payload: got %h/%h expected 10/12345678", t_wa, t_wd);
        else pass_cnt++;
        // Read data from the previous read is untouched by a write.
        total_cnt++;
        if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0)
            $display("FAIL write_rdata_hold: got %h err %b expected deadbeef err 0", t_rdata, t_err);
        else pass_cnt++;
        end_txn();
    endtask

    task automatic test_errors();
        logic       rds[3] = '{1'b1, 1'b0, 1'b1};
        logic       wrs[3] = '{1'b0, 1'b1, 1'b1};
        logic [5:0] ads[3] = '{6'h0C, 6'h15, 6'h03};
        for (int i = 0; i < 3; i++) begin
            run_txn(rds[i], wrs[i], ads[i], 32'hFFFFFFFF, 32'h77777777, 1'b0);
            total_cnt++;
            if (t_lat !== 1 || t_err !== 1'b1)
                $display("FAIL error_%0d_resp: got lat %0d err %b expected lat 1 err 1", i, t_lat, t_err);
            else pass_cnt++;
            total_cnt++;
            if (t_nrd !== 0 || t_nwr !== 0 || t_rdata !== 32'h0)
                $display("FAIL error_%0d_side: got rd %0d wr %0d rdata %h expected 0 0 0", i, t_nrd, t_nwr, t_rdata);
            else pass_cnt++;
            end_txn();
        end
        // A valid request after an error clears o_err.
        run_txn(1'b0, 1'b1, 6'h00, 32'h0000ABCD, 32'h0, 1'b0);
        total_cnt++;
        if (t_err !== 1'b0 || t_lat !== 2)
            $display("FAIL error_clear: got err %b lat %0d expected err 0 lat 2", t_err, t_lat);
        else pass_cnt++;
        end_txn();
    endtask

    task automatic test_addr_bounds();
        logic       rds[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [5:0] ads[11] = '{6'h08, 6'h09, 6'h13, 6'h14, 6'h20, 6'h21, 6'h00,
                                6'h13, 6'h14, 6'h00, 6'h3F};
        logic       ers[11] = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1};
        int exp_lat;
        for (int i = 0; i < 11; i++) begin
            run_txn(rds[i], !rds[i], ads[i], 32'h5A5A0000 + i, 32'h00C0FFEE + i, 1'b0);
            exp_lat = ers[i] ? 1 : (rds[i] ? 4 : 2);
            total_cnt++;
            if (t_err !== ers[i] || t_lat !== exp_lat)
                $display("FAIL bound_%s_%h: got err %b lat %0d expected err %b lat %0d",
                         rds[i] ? "rd" : "wr", ads[i], t_err, t_lat, ers[i], exp_lat);
            else pass_cnt++;
            end_txn();
        end
    endtask

    task automatic test_hold();
        int n_ready = 0;
        int n_rd = 0;
        i_cs = 1'b1; i_rd = 1'b1; i_wr = 1'b0; i_addr = 6'h01; i_rd_data = 32'h11112222;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (o_ready) n_ready++;
            if (o_rd_en) n_rd++;
        end
        total_cnt++;
        if (n_ready !== 1 || n_rd !== 3)
            $display("FAIL hold_single_pulse: got ready %0d rd_en %0d expected 1 3", n_ready, n_rd);
        else pass_cnt++;
        i_cs = 1'b0;
        tick();
        total_cnt++;
        if (o_rd_en !== 1'b0) $display("FAIL hold_exit_no_accept: got rd_en %b expected 0", o_rd_en);
        else pass_cnt++;
        i_cs = 1'b1;
        tick();
        total_cnt++;
        if (o_rd_en !== 1'b1) $display("FAIL hold_reaccept: got rd_en %b expected 1", o_rd_en);
        else pass_cnt++;
        end_txn();
        end_txn();
    endtask

    task automatic test_cs_drop();
        run_txn(1'b0, 1'b1, 6'h05, 32'hA5A5A5A5, 32'h0, 1'b1);
        total_cnt++;
        if (t_lat !== 2 || t_nwr !== 1 || t_wd !== 32'hA5A5A5A5)
            $display("FAIL cs_drop_complete: got lat %0d wr %0d data %h expected 2 1 a5a5a5a5", t_lat, t_nwr, t_wd);
        else pass_cnt++;
        tick();
        tick();
        i_cs = 1'b1; i_wr = 1'b1; i_rd = 1'b0; i_addr = 6'h06; i_wdata = 32'h0BADF00D;
        tick();
        total_cnt++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 6'h06)
            $display("FAIL cs_drop_hold_exit: got wr_en %b addr %h expected 1 06", o_wr_en, o_wr_addr);
        else pass_cnt++;
        end_txn();
    endtask

    task automatic test_reset_mid();
        int n_ready = 0;
        i_cs = 1'b1; i_rd = 1'b1; i_wr = 1'b0; i_addr = 6'h04; i_rd_data = 32'h55555555;
        tick();
        tick();
        i_reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({o_rd_en, o_ack, o_wr_en, o_ready, o_err} !== 5'b0 || o_rdata !== 32'h0 || o_rd_addr !== 6'h0)
            $display("FAIL reset_mid_outputs: got %b rdata %h addr %h expected 00000 0 0",
                     {o_rd_en, o_ack, o_wr_en, o_ready, o_err}, o_rdata, o_rd_addr);
        else pass_cnt++;
        i_cs = 1'b0; i_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_ready || o_wr_en || o_rd_en) n_ready++;
        end
        total_cnt++;
        if (n_ready !== 0) $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", n_ready);
        else pass_cnt++;
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        run_txn(1'b1, 1'b0, 6'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        total_cnt++;
        if (t_lat !== 4 || t_rdata !== 32'hCAFEF00D || t_err !== 1'b0 || t_nrd !== 3)
            $display("FAIL reset_mid_recover: got lat %0d rdata %h err %b rd %0d expected 4 cafef00d 0 3",
                     t_lat, t_rdata, t_err, t_nrd);
        else pass_cnt++;
        end_txn();
    endtask

    // ---- sequence and report ----
    initial begin
        test_reset();
        test_read();
        test_write();
        test_errors();
        test_addr_bounds();
        test_hold();
        test_cs_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
